// File: rtl/arm_run_pkg.sv
// Shared types and constants for the ARM run controller and its PC trace buffer.
package arm_run_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRstHold,
        StRun,
        StDrain,
        StDone,
        StTimeout
    } run_state_t;

    // HLT #0
    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hD440_0000;

    // Index width for a table of the given depth; never narrower than one bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        w = 0;
        while ((32'd1 << w) < value) begin
            w++;
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/arm_pc_trace_buf.sv
// Circular buffer of recent core PCs; consecutive duplicate PCs are stored only once.
module arm_pc_trace_buf
    import arm_run_pkg::*;
#(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DEPTH  = 8,
    localparam int unsigned IdxW  = clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              wr_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [IdxW-1:0]   rd_idx_i,
    output logic [ADDR_W-1:0] rd_pc_o,
    output logic              rd_valid_o
);

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [IdxW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [IdxW:0]     count_q, count_d;
    logic [IdxW-1:0]   newest_ptr;
    logic [IdxW-1:0]   rd_ptr;
    logic              wr_en;

    assign newest_ptr = wr_ptr_q - IdxW'(1);
    assign rd_ptr     = newest_ptr - rd_idx_i;
    assign wr_en      = wr_i && !clr_i && ((count_q == '0) || (mem_q[newest_ptr] != pc_i));
    assign rd_pc_o    = mem_q[rd_ptr];
    assign rd_valid_o = ({1'b0, rd_idx_i} < count_q);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            count_d  = '0;
        end else if (wr_en) begin
            wr_ptr_d = wr_ptr_q + IdxW'(1);
            if (count_q != (IdxW + 1)'(DEPTH)) begin
                count_d = count_q + (IdxW + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entries beyond count_q are never reported valid, so the storage needs no reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= pc_i;
        end
    end

endmodule

// File: rtl/arm_run_controller.sv
// Run controller for the pipelined ARM core: reset sequencing, halt detection, drain, timeout.
// Optional PC trace buffer enabled by defining RUN_TRACE_EN.
module arm_run_controller
    import arm_run_pkg::*;
#(
    parameter int unsigned         ADDR_W       = 64,
    parameter int unsigned         INSTR_W      = 32,
    parameter int unsigned         CNT_W        = 32,
    parameter int unsigned         RESET_CYCLES = 2,
    parameter int unsigned         MAX_CYCLES   = 22,
    parameter int unsigned         PIPE_DEPTH   = 5,
    parameter logic [INSTR_W-1:0]  HALT_WORD    = INSTR_W'(HALT_WORD_DEFAULT),
    parameter int unsigned         TRACE_DEPTH  = 8,
    localparam int unsigned        IdxW         = clog2(TRACE_DEPTH)
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic               start_i,
    input  logic [ADDR_W-1:0]  pc_i,
    input  logic [INSTR_W-1:0] instr_i,
    output logic               cpu_reset_o,
    output logic               running_o,
    output logic               done_o,
    output logic               timeout_o,
    output logic [CNT_W-1:0]   cycle_count_o,
    output logic [ADDR_W-1:0]  halt_pc_o,
    input  logic [IdxW-1:0]    trace_idx_i,
    output logic [ADDR_W-1:0]  trace_pc_o,
    output logic               trace_valid_o
);

    localparam int unsigned PhMax = (RESET_CYCLES > PIPE_DEPTH) ? RESET_CYCLES : PIPE_DEPTH;
    localparam int unsigned PhW   = clog2(PhMax);
    localparam logic [PhW-1:0]   RstLast   = PhW'(RESET_CYCLES - 1);
    localparam logic [PhW-1:0]   DrainLast = PhW'(PIPE_DEPTH - 1);
    localparam logic [CNT_W-1:0] MaxLast   = CNT_W'(MAX_CYCLES - 1);

    run_state_t        state_q, state_d;
    logic [PhW-1:0]    phase_q, phase_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] halt_pc_q, halt_pc_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              running_q, running_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;
    logic              trace_clr;
    logic              trace_wr;
    logic [CNT_W-1:0]  count_inc;

    assign count_inc = (count_q == '1) ? count_q : count_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        count_d   = count_q;
        halt_pc_d = halt_pc_q;
        trace_clr = 1'b0;
        trace_wr  = 1'b0;
        case (state_q)
            StIdle, StDone, StTimeout: begin
                if (start_i) begin
                    state_d   = StRstHold;
                    phase_d   = '0;
                    count_d   = '0;
                    halt_pc_d = '0;
                    trace_clr = 1'b1;
                end
            end
            StRstHold: begin
                if (phase_q == RstLast) begin
                    state_d = StRun;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + PhW'(1);
                end
            end
            StRun: begin
                count_d  = count_inc;
                trace_wr = 1'b1;
                // Halt takes priority over budget expiry on the same cycle.
                if (instr_i == HALT_WORD) begin
                    halt_pc_d = pc_i;
                    state_d   = StDrain;
                    phase_d   = '0;
                end else if ((MAX_CYCLES != 0) && (count_q == MaxLast)) begin
                    state_d = StTimeout;
                end
            end
            StDrain: begin
                count_d  = count_inc;
                trace_wr = 1'b1;
                if (phase_q == DrainLast) begin
                    state_d = StDone;
                end else begin
                    phase_d = phase_q + PhW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        running_d   = (state_d == StRun) || (state_d == StDrain);
        cpu_reset_d = !running_d;
        done_d      = (state_d == StDone);
        timeout_d   = (state_d == StTimeout);
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= StIdle;
            phase_q     <= '0;
            count_q     <= '0;
            halt_pc_q   <= '0;
            cpu_reset_q <= 1'b1;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            count_q     <= count_d;
            halt_pc_q   <= halt_pc_d;
            cpu_reset_q <= cpu_reset_d;
            running_q   <= running_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
        end
    end

    assign cpu_reset_o   = cpu_reset_q;
    assign running_o     = running_q;
    assign done_o        = done_q;
    assign timeout_o     = timeout_q;
    assign cycle_count_o = count_q;
    assign halt_pc_o     = halt_pc_q;

`ifdef RUN_TRACE_EN
    arm_pc_trace_buf #(
        .ADDR_W (ADDR_W),
        .DEPTH  (TRACE_DEPTH)
    ) u_trace (
        .clk_i      (CLOCK),
        .rst_ni     (RESET),
        .clr_i      (trace_clr),
        .wr_i       (trace_wr),
        .pc_i       (pc_i),
        .rd_idx_i   (trace_idx_i),
        .rd_pc_o    (trace_pc_o),
        .rd_valid_o (trace_valid_o)
    );
`else
    logic unused_trace;
    assign unused_trace  = ^{trace_idx_i, trace_clr, trace_wr};
    assign trace_pc_o    = '0;
    assign trace_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_arm_run_controller.sv
// Directed bench for arm_run_controller with default parameters.
module tb_arm_run_controller;

    localparam logic [31:0] HALT = 32'hD440_0000;
    localparam logic [31:0] NOP  = 32'h8B1F_03E0;

    logic        CLOCK;
    logic        RESET;
    logic        start;
    logic [63:0] pc;
    logic [31:0] instr;
    logic        cpu_reset;
    logic        running;
    logic        done;
    logic        timeout;
    logic [31:0] cycle_count;
    logic [63:0] halt_pc;
    logic [2:0]  trace_idx;
    logic [63:0] trace_pc;
    logic        trace_valid;

    int n_vec;
    int n_err;

    arm_run_controller dut (
        .CLOCK         (CLOCK),
        .RESET         (RESET),
        .start_i       (start),
        .pc_i          (pc),
        .instr_i       (instr),
        .cpu_reset_o   (cpu_reset),
        .running_o     (running),
        .done_o        (done),
        .timeout_o     (timeout),
        .cycle_count_o (cycle_count),
        .halt_pc_o     (halt_pc),
        .trace_idx_i   (trace_idx),
        .trace_pc_o    (trace_pc),
        .trace_valid_o (trace_valid)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cpu_reset"}, 64'(cpu_reset), 64'd1);
        check({tag, "_running"}, 64'(running), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_timeout"}, 64'(timeout), 64'd0);
        check({tag, "_count"}, 64'(cycle_count), 64'd0);
        check({tag, "_halt_pc"}, halt_pc, 64'd0);
    endtask

    // start pulse plus RESET_CYCLES=2 hold; returns at the start of RUN cycle 1
    task automatic enter_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        RESET     = 1'b0;
        start     = 1'b0;
        pc        = '0;
        instr     = NOP;
        trace_idx = '0;

        tick();
        tick();
        check_reset_vals("rst");
        check("rst_trace_valid", 64'(trace_valid), 64'd0);
        RESET = 1'b1;
        tick();
        check_reset_vals("idle");

        // Reset hold sequence
        start = 1'b1;
        tick();
        start = 1'b0;
        check("hold1_cpu_reset", 64'(cpu_reset), 64'd1);
        check("hold1_running", 64'(running), 64'd0);
        tick();
        check("hold2_cpu_reset", 64'(cpu_reset), 64'd1);
        tick();
        check("run_cpu_reset", 64'(cpu_reset), 64'd0);
        check("run_running", 64'(running), 64'd1);

        // Halt on RUN cycle 7 at pc 0x1C
        for (int k = 1; k <= 6; k++) begin
            pc = 64'(4 * k);
            tick();
        end
        pc    = 64'h1C;
        instr = HALT;
        tick();
        check("drain_running", 64'(running), 64'd1);
        check("drain_count", 64'(cycle_count), 64'd7);
        check("drain_halt_pc", halt_pc, 64'h1C);
        pc = 64'h20;
        for (int k = 1; k <= 4; k++) tick();
        check("drain4_done", 64'(done), 64'd0);
        instr = NOP;
        tick();
        check("halt_done", 64'(done), 64'd1);
        check("halt_count", 64'(cycle_count), 64'd12);
        check("halt_cpu_reset", 64'(cpu_reset), 64'd1);
        check("halt_running", 64'(running), 64'd0);
        check("halt_timeout", 64'(timeout), 64'd0);
        tick();
        tick();
        check("held_count", 64'(cycle_count), 64'd12);
        check("held_halt_pc", halt_pc, 64'h1C);

        // Timeout after 22 RUN cycles
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_done_clr", 64'(done), 64'd0);
        check("restart_count_clr", 64'(cycle_count), 64'd0);
        check("restart_halt_pc_clr", halt_pc, 64'd0);
        tick();
        tick();
        for (int k = 1; k <= 21; k++) begin
            pc = 64'(4 * k);
            tick();
        end
        check("to21_timeout", 64'(timeout), 64'd0);
        check("to21_running", 64'(running), 64'd1);
        tick();
        check("to_timeout", 64'(timeout), 64'd1);
        check("to_count", 64'(cycle_count), 64'd22);
        check("to_done", 64'(done), 64'd0);
        check("to_running", 64'(running), 64'd0);
        check("to_cpu_reset", 64'(cpu_reset), 64'd1);

        // Halt on the 22nd RUN cycle beats the budget
        enter_run();
        check("t4_timeout_clr", 64'(timeout), 64'd0);
        for (int k = 1; k <= 21; k++) begin
            pc = 64'(4 * k);
            tick();
        end
        pc    = 64'h58;
        instr = HALT;
        tick();
        instr = NOP;
        check("t4_running", 64'(running), 64'd1);
        check("t4_timeout", 64'(timeout), 64'd0);
        check("t4_count", 64'(cycle_count), 64'd22);
        for (int k = 1; k <= 5; k++) tick();
        check("t4_done", 64'(done), 64'd1);
        check("t4_timeout_end", 64'(timeout), 64'd0);
        check("t4_count_end", 64'(cycle_count), 64'd27);
        check("t4_halt_pc", halt_pc, 64'h58);

        // start during RUN ignored, then async reset during DRAIN
        enter_run();
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t5_ign_running", 64'(running), 64'd1);
        check("t5_ign_cpu_reset", 64'(cpu_reset), 64'd0);
        check("t5_ign_count", 64'(cycle_count), 64'd3);
        instr = HALT;
        tick();
        instr = NOP;
        tick();
        tick();
        check("t5_drain_count", 64'(cycle_count), 64'd6);
        #3;
        RESET = 1'b0;
        #1;
        check_reset_vals("t5_async");
        tick();
        check_reset_vals("t5_held");
        RESET = 1'b1;
        tick();
        check("t5_idle_running", 64'(running), 64'd0);
        enter_run();
        check("t5_clean_running", 64'(running), 64'd1);
        check("t5_clean_count", 64'(cycle_count), 64'd0);
        tick();
        tick();
        pc    = 64'h100;
        instr = HALT;
        tick();
        instr = NOP;
        check("t5_clean_halt_pc", halt_pc, 64'h100);
        for (int k = 1; k <= 5; k++) tick();
        check("t5_clean_done", 64'(done), 64'd1);
        check("t5_clean_count_end", 64'(cycle_count), 64'd8);

        // PC trace
        start = 1'b1;
        tick();
        start = 1'b0;
        check("tr_clr_valid", 64'(trace_valid), 64'd0);
        tick();
        tick();
        for (int k = 0; k <= 8; k++) begin
            pc = 64'(4 * k);
            tick();
        end
        pc = 64'd32;
        tick();
        pc = 64'd36;
        tick();
        pc    = 64'd40;
        instr = HALT;
        tick();
        instr = NOP;
        for (int k = 1; k <= 5; k++) tick();
        check("tr_done", 64'(done), 64'd1);
`ifdef RUN_TRACE_EN
        trace_idx = 3'd0;
        #1;
        check("tr_idx0_pc", trace_pc, 64'd40);
        check("tr_idx0_valid", 64'(trace_valid), 64'd1);
        trace_idx = 3'd1;
        #1;
        check("tr_idx1_pc", trace_pc, 64'd36);
        trace_idx = 3'd2;
        #1;
        check("tr_idx2_pc", trace_pc, 64'd32);
        trace_idx = 3'd7;
        #1;
        check("tr_idx7_pc", trace_pc, 64'd12);
        check("tr_idx7_valid", 64'(trace_valid), 64'd1);
`else
        trace_idx = 3'd0;
        #1;
        check("tr_off_valid0", 64'(trace_valid), 64'd0);
        check("tr_off_pc0", trace_pc, 64'd0);
        trace_idx = 3'd7;
        #1;
        check("tr_off_valid7", 64'(trace_valid), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
